ram_req_ctrl: RTL and testbench
===============================

# ram_req_ctrl

Request sequencer that sits directly upstream of the 16x8 single-port RAM and is the only block that drives its enables. It accepts single-word read/write requests over a valid/ready handshake and converts them into one-hot `w_en`/`r_en` pulses. It returns read data with a response-valid strobe aligned to the RAM's registered output. It also runs a full-memory clear sweep on command, because RAM reset clears only `dout`, not the array.

## Interface
- `AW`, 4: address width; `DEPTH = 2**AW` words.
- `DW`, 8: data width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset is asynchronous and active-low. There is one clock.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the controller can accept a request this cycle.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in AW: request address.
- `req_wdata` in DW: write data.
- `clr_start` in 1: one-cycle pulse that starts a full clear.
- `busy` out 1: a clear is in progress.
- `clr_done` out 1: one-cycle pulse after the last clear write is issued.
- `rsp_valid` out 1: read response is valid.
- `rsp_addr` out AW: address of the returned word.
- `rsp_data` out DW: returned word, passed through from `ram_dout`.
- `ram_w_en`, `ram_r_en` out 1: RAM enables, never both high.
- `ram_addr` out AW: RAM address.
- `ram_din` out DW: RAM write data.
- `ram_dout` in DW: RAM registered read data.

## Operation
- **States:**
  - IDLE: accepts requests.
  - CLEAR: sweeps addresses with zero writes.
- **Handshake:**
  - `req_ready = (state==IDLE) && !clr_start`.
  - A request is accepted on a rising edge where `req_valid && req_ready`.
  - `req_valid` may drop without acceptance. There is no ordering obligation on unaccepted requests.
  - Throughput is one request per cycle. Back-to-back reads, writes, or any mix are allowed.
- **Write accept:** in the next cycle, `ram_w_en=1`, `ram_r_en=0`, `ram_addr`/`ram_din` = the accepted values. The RAM commits the write at the end of that cycle.
- **Read accept:** in the next cycle, `ram_r_en=1`, `ram_w_en=0`, `ram_addr` = the accepted address.
  - One cycle later, `rsp_valid=1` and `rsp_addr` = that address.
  - `rsp_data` = `ram_dout`.
  - There is no response backpressure; the consumer must always sink.
- **Idle outputs:** with no accepted request, both enables are 0 the next cycle. `ram_addr`/`ram_din` hold their last values.
- **CLEAR entry:** `clr_start` sampled high in IDLE moves the block to CLEAR.
  - The address counter is loaded with 0 and `busy=1` from the next cycle.
  - A `req_valid` in the same cycle is not accepted, because clear has priority.
- **CLEAR sweep:** each cycle issues `ram_w_en=1`, `ram_din=0`, `ram_addr=cnt`, then `cnt++`.
  - After address `DEPTH-1` is issued, `clr_done` pulses for one cycle in the following cycle, `busy` falls, and the state returns to IDLE.
  - Total is DEPTH write cycles (16 at default).
- **`clr_start` during CLEAR:** ignored; the sweep does not restart.
- **In-flight read when clear starts:** a read issued in the cycle before CLEAR entry completes normally, and its `rsp_valid` still fires. The first clear write follows it in the next cycle with no collision.
- **Address width:** address arithmetic is modulo `2**AW`. The sweep counter is AW+1 bits wide, or it uses a terminal-count flag, so that it never re-wraps.

## Timing
- **Reset values:** `rst_n` low asynchronously forces state=IDLE, cnt=0, and every output to 0: `req_ready` = !clr_start, and `busy`, `clr_done`, `rsp_valid`, `rsp_addr`, `rsp_data`, the RAM enables, `ram_addr` and `ram_din` are all 0.
  - `rsp_data` follows `ram_dout`. The RAM clears `dout` on its own reset, which must be tied to the same reset.
- **Reset mid-clear:** the sweep aborts, the memory is left partially cleared, and no `clr_done` is produced.
- **Reset with a read in flight:** the response is dropped.
- **Latency:** write is 1 cycle from accept to RAM enable. Read is 2 cycles from accept to `rsp_valid`.
- **Clear:** `clr_start` edge → `busy` high next cycle. `busy` stays high for DEPTH cycles. `clr_done` is coincident with the first cycle `busy` is low, and `req_ready` may be high in that same cycle.

## Structure
- Shared package `ram_pkg`: `AW`/`DW` defaults, `DEPTH`, and the state enum `{IDLE, CLEAR}`.
- Sub-module `ram_clear_seq` (counter, terminal count, `clr_done`) is natural. The top block muxes its address/data onto the RAM port.
- The top-level testbench instantiates this block together with `single_port_ram` (configured n=AW, data DW).

## Test plan
- Write 0xA5 to address 3, then read address 3 → `rsp_valid` 2 cycles after accept, `rsp_addr=3`, `rsp_data=0xA5`.
- 16 back-to-back writes of random data to addresses 0..15, then 16 back-to-back reads → 16 consecutive `rsp_valid` cycles whose data matches the TB model in order, with `req_ready` held high throughout.
- Fill memory with non-zero data, pulse `clr_start` → `busy` high for exactly 16 cycles, `req_ready` low, one `clr_done`; readback of all 16 addresses returns 0x00.
- Read address 7, then assert `clr_start` in the next cycle → the response for address 7 carries the pre-clear data, and the clear then completes normally.
- `clr_start` and `req_valid` (write 0x3C to address 0) in the same IDLE cycle → request not accepted; after `clr_done`, address 0 reads 0x00.
- Assert `rst_n` low at clear address 8 → outputs are 0 immediately, no `clr_done`; afterwards addresses 0..7 read 0 and addresses 8..15 retain their old data.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared parameters and FSM state type for the RAM request sequencer.
package ram_pkg;
  localparam int AW_DEF    = 4;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 2 ** AW_DEF;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ctrl_state_e;
endpackage

// File: rtl/ram_clear_seq.sv
// Clear-sweep address counter: walks 0..DEPTH-1 while enabled and pulses clr_done after the last address.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          en,
  output logic [AW-1:0] cnt,
  output logic          last,
  output logic          clr_done
);
  // Terminal count is all-ones; the counter parks at 0 afterwards instead of re-wrapping.
  assign last = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= en && last;
      if (start || (en && last)) cnt <= '0;
      else if (en)               cnt <= cnt + AW'(1);
    end
  end
endmodule

// File: rtl/single_port_ram.sv
// Single-port RAM with registered read data; reset clears dout only, never the array.
module single_port_ram #(
  parameter int n    = 4,
  parameter int data = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            w_en,
  input  logic            r_en,
  input  logic [n-1:0]    addr,
  input  logic [data-1:0] din,
  output logic [data-1:0] dout
);
  logic [data-1:0] mem [2**n];

  always_ff @(posedge clk) begin
    if (w_en) mem[addr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    dout <= '0;
    else if (r_en) dout <= mem[addr];
  end
endmodule

// File: rtl/ram_req_ctrl.sv
// Request sequencer for the single-port RAM: valid/ready requests in, one-hot RAM enables out,
// read responses aligned to the RAM's registered dout, plus a full-memory zero sweep.
//
//   state | meaning
//   IDLE  | accepts read/write requests
//   CLEAR | issues one zero write per cycle, addresses 0..DEPTH-1
module ram_req_ctrl
  import ram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic          clr_start,
  output logic          busy,
  output logic          clr_done,
  output logic          rsp_valid,
  output logic [AW-1:0] rsp_addr,
  output logic [DW-1:0] rsp_data,
  output logic          ram_w_en,
  output logic          ram_r_en,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);
  ctrl_state_e   state, state_nxt;
  logic          accept;
  logic          clr_go;
  logic          clr_last;
  logic [AW-1:0] clr_addr;
  logic          wr_q, rd_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;

  assign req_ready = (state == IDLE) && !clr_start;
  assign accept    = req_valid && req_ready;
  assign clr_go    = (state == IDLE) && clr_start;
  assign busy      = (state == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_start) state_nxt = CLEAR;
      CLEAR:   if (clr_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  ram_clear_seq #(.AW(AW)) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (clr_go),
    .en       (busy),
    .cnt      (clr_addr),
    .last     (clr_last),
    .clr_done (clr_done)
  );

  // During a sweep the port registers track the clear address so they hold the last issued
  // values once the block drops back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
    end else begin
      wr_q      <= accept && req_write;
      rd_q      <= accept && !req_write;
      rsp_valid <= rd_q;
      if (rd_q) rsp_addr <= addr_q;
      if (accept) begin
        addr_q <= req_addr;
        if (req_write) din_q <= req_wdata;
      end else if (busy) begin
        addr_q <= clr_addr;
        din_q  <= '0;
      end
    end
  end

  // A read can only be in its enable cycle when the sweep has not yet started, so the enables stay one-hot.
  assign ram_w_en = wr_q | busy;
  assign ram_r_en = rd_q;
  assign ram_addr = busy ? clr_addr : addr_q;
  assign ram_din  = busy ? '0 : din_q;
  assign rsp_data = ram_dout;
endmodule

// File: tb/tb_ram_req_ctrl.sv
// Bench for ram_req_ctrl + single_port_ram: a cycle-schedule model checked every negedge,
// plus directed scenarios with literal expectations.
module tb_ram_req_ctrl;
  import ram_pkg::*;

  localparam int AW    = AW_DEF;
  localparam int DW    = DW_DEF;
  localparam int DEPTH = DEPTH_DEF;
  localparam int NS    = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0, clr_start = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, busy, clr_done, rsp_valid, ram_w_en, ram_r_en;
  logic [AW-1:0] rsp_addr, ram_addr;
  logic [DW-1:0] rsp_data, ram_din, ram_dout;

  always #5 clk = ~clk;

  ram_req_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .ram_w_en(ram_w_en), .ram_r_en(ram_r_en), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  single_port_ram #(.n(AW), .data(DW)) u_ram (
    .clk(clk), .rst_n(rst_n), .w_en(ram_w_en), .r_en(ram_r_en),
    .addr(ram_addr), .din(ram_din), .dout(ram_dout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: what each future cycle must show, filled in when a request or clear is accepted.
  typedef struct packed {
    logic          w, r, bsy, done, rv;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
  } slot_t;

  slot_t         slots [NS];
  logic [DW-1:0] mem_m [DEPTH];
  int            cyc = 0;
  int            clr_end = -1;

  initial for (int i = 0; i < NS; i++) slots[i] = '0;

  always @(negedge clk) begin
    slot_t s;
    logic  exp_ready;
    if (!rst_n) begin
      chk("rst_w_en", 32'(ram_w_en), 0);
      chk("rst_r_en", 32'(ram_r_en), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      chk("rst_ram_din", 32'(ram_din), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_clr_done", 32'(clr_done), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_addr", 32'(rsp_addr), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_req_ready", 32'(req_ready), 32'(!clr_start));
      for (int i = 0; i < NS; i++) slots[i] = '0;
      clr_end = -1;
    end else begin
      s = slots[cyc % NS];
      exp_ready = (cyc > clr_end) && !clr_start;
      chk("w_en", 32'(ram_w_en), 32'(s.w));
      chk("r_en", 32'(ram_r_en), 32'(s.r));
      chk("busy", 32'(busy), 32'(s.bsy));
      chk("clr_done", 32'(clr_done), 32'(s.done));
      chk("rsp_valid", 32'(rsp_valid), 32'(s.rv));
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      if (s.w || s.r) chk("ram_addr", 32'(ram_addr), 32'(s.addr));
      if (s.w) chk("ram_din", 32'(ram_din), 32'(s.din));
      if (s.rv) begin
        chk("rsp_addr", 32'(rsp_addr), 32'(s.raddr));
        chk("rsp_data", 32'(rsp_data), 32'(s.rdata));
      end
      if (s.w) mem_m[s.addr] = s.din;
      if (s.r) begin
        slots[(cyc + 1) % NS].rv    = 1'b1;
        slots[(cyc + 1) % NS].raddr = s.addr;
        slots[(cyc + 1) % NS].rdata = mem_m[s.addr];
      end
      if (cyc > clr_end && clr_start) begin
        for (int i = 1; i <= DEPTH; i++) begin
          slots[(cyc + i) % NS].w    = 1'b1;
          slots[(cyc + i) % NS].bsy  = 1'b1;
          slots[(cyc + i) % NS].addr = AW'(i - 1);
          slots[(cyc + i) % NS].din  = '0;
        end
        slots[(cyc + DEPTH + 1) % NS].done = 1'b1;
        clr_end = cyc + DEPTH;
      end else if (exp_ready && req_valid) begin
        slots[(cyc + 1) % NS].w    = req_write;
        slots[(cyc + 1) % NS].r    = !req_write;
        slots[(cyc + 1) % NS].addr = req_addr;
        slots[(cyc + 1) % NS].din  = req_wdata;
      end
      slots[cyc % NS] = '0;
    end
    cyc++;
  end

  // Driver: all input changes happen 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d;
    step();
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    drive(1'b1, 1'b0, a, '0);
    req_valid = 1'b0;
    step();
    chk("lit_rsp_valid", 32'(rsp_valid), 1);
    chk("lit_rsp_addr", 32'(rsp_addr), 32'(a));
    chk("lit_rsp_data", 32'(rsp_data), 32'(exp));
  endtask

  task automatic clr_pulse();
    req_valid = 1'b0;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
  endtask

  task automatic wait_done();
    logic found = 1'b0;
    for (int j = 0; j < 40 && !found; j++) begin
      if (clr_done) found = 1'b1;
      else step();
    end
    chk("clr_done_seen", 32'(found), 1);
    step();
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, AW'(i), '0);
    idle(3);
  endtask

  initial begin
    int          bcount, dcount, vcount;
    logic        found;
    logic [DW-1:0] wd;

    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Basic write then read.
    drive(1'b1, 1'b1, 4'd3, 8'hA5);
    rd_chk(4'd3, 8'hA5);
    idle(2);

    // Back-to-back writes then reads; ready must stay high.
    for (int i = 0; i < DEPTH; i++) begin
      wd = 8'($urandom);
      drive(1'b1, 1'b1, AW'(i), wd);
    end
    vcount = 0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, AW'(i), '0);
      if (rsp_valid) vcount++;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (rsp_valid) vcount++;
    end
    chk("burst_rsp_count", 32'(vcount), 16);

    // Full clear after a non-zero fill.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, AW'(i), 8'h10 + 8'(i));
    idle(1);
    clr_pulse();
    bcount = 0;
    dcount = 0;
    for (int j = 0; j < 25; j++) begin
      if (busy) bcount++;
      if (clr_done) dcount++;
      step();
    end
    chk("clear_busy_cycles", 32'(bcount), 16);
    chk("clear_done_pulses", 32'(dcount), 1);
    read_all();
    rd_chk(4'd5, 8'h00);
    idle(1);

    // Read in flight when the clear starts.
    drive(1'b1, 1'b1, 4'd7, 8'h77);
    drive(1'b1, 1'b0, 4'd7, '0);
    clr_pulse();
    chk("inflight_rsp_valid", 32'(rsp_valid), 1);
    chk("inflight_rsp_data", 32'(rsp_data), 32'h77);
    chk("inflight_busy", 32'(busy), 1);
    wait_done();
    rd_chk(4'd7, 8'h00);
    idle(1);

    // Clear has priority over a same-cycle request.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd0; req_wdata = 8'h3C;
    clr_start = 1'b1;
    #1;
    chk("clr_vs_req_ready", 32'(req_ready), 0);
    step();
    clr_start = 1'b0;
    req_valid = 1'b0;
    wait_done();
    rd_chk(4'd0, 8'h00);
    idle(1);

    // Reset in the middle of a sweep.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, AW'(i), 8'h90 + 8'(i));
    idle(1);
    clr_pulse();
    found = 1'b0;
    for (int j = 0; j < 30 && !found; j++) begin
      if (busy && ram_addr == 4'd8) found = 1'b1;
      else step();
    end
    chk("reached_clear_addr8", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("midclr_w_en", 32'(ram_w_en), 0);
    chk("midclr_busy", 32'(busy), 0);
    chk("midclr_ram_addr", 32'(ram_addr), 0);
    dcount = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (clr_done) dcount++;
    end
    rst_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      step();
      if (clr_done) dcount++;
    end
    chk("midclr_no_done", 32'(dcount), 0);
    read_all();
    rd_chk(4'd2, 8'h00);
    rd_chk(4'd12, 8'h9C);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
